// File: rtl/reg_file_pkg.sv
// Shared defaults and index type for the register file and its stack-pointer unit.
package reg_file_pkg;
    localparam int                 DEF_WIDTH    = 16;
    localparam int                 DEF_NREGS    = 8;
    localparam int                 DEF_ADDR_W   = $clog2(DEF_NREGS);
    localparam logic [DEF_WIDTH-1:0] DEF_SP_RESET = '1;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_if.sv
// Read/write/stack bus between the datapath controller (master) and the register file (slave).
interface reg_file_if #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = $clog2(NREGS)
) ();
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              sp_push;
    logic              sp_pop;
    logic [WIDTH-1:0]  sp_out;
    logic              sp_ovf;
    logic              sp_unf;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_push, sp_pop,
        input  rd_data_a, rd_data_b, sp_out, sp_ovf, sp_unf
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_push, sp_pop,
        output rd_data_a, rd_data_b, sp_out, sp_ovf, sp_unf
    );
endinterface

// File: rtl/reg_file_sp_unit.sv
// Saturating stack pointer with sticky overflow/underflow flags.
module sp_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] SP_RESET = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] sp_out,
    output logic             sp_ovf,
    output logic             sp_unf
);
    logic [WIDTH-1:0] sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Simultaneous push and pop cancel out and leave the flags untouched.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        unique case ({push, pop})
            2'b10: begin
                sp_d = dec_sat(sp_q);
                if (sp_q == '0) ovf_d = 1'b1;
            end
            2'b01: begin
                sp_d = inc_sat(sp_q);
                if (sp_q == '1) unf_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= SP_RESET;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sp_out = sp_q;
    assign sp_ovf = ovf_q;
    assign sp_unf = unf_q;
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-through bypass and a saturating stack pointer.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               NREGS    = DEF_NREGS,
    parameter logic [WIDTH-1:0] SP_RESET = '1
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en) regs_d[bus.wr_addr] = bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is purely combinational, so it stays live even while reset is held.
    assign bus.rd_data_a = (bus.wr_en && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data
                                                                       : regs_q[bus.rd_addr_a];
    assign bus.rd_data_b = (bus.wr_en && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data
                                                                       : regs_q[bus.rd_addr_b];

    sp_unit #(
        .WIDTH    (WIDTH),
        .SP_RESET (SP_RESET)
    ) u_sp_unit (
        .clk    (clk),
        .reset  (reset),
        .push   (bus.sp_push),
        .pop    (bus.sp_pop),
        .sp_out (bus.sp_out),
        .sp_ovf (bus.sp_ovf),
        .sp_unf (bus.sp_unf)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reads, bypass, stack-pointer saturation and reset priority.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(16), .NREGS(8)) bus  ();
    reg_file_if #(.WIDTH(16), .NREGS(8)) bus2 ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Second instance starts near zero so the overflow corner is reached in a few pushes.
    reg_file #(.WIDTH(16), .NREGS(8), .SP_RESET(16'h0003)) dut_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.sp_push  = 1'b0;
        bus.sp_pop   = 1'b0;
        bus2.sp_push = 1'b0;
        bus2.sp_pop  = 1'b0;
    endtask

    task automatic read_check(input string tag, input reg_idx_t idx, input logic [15:0] exp);
        bus.rd_addr_a = idx;
        bus.rd_addr_b = idx;
        #1;
        check({tag, "_a"}, bus.rd_data_a, exp);
        check({tag, "_b"}, bus.rd_data_b, exp);
    endtask

    task automatic sp_step(input logic push, input logic pop, input logic [15:0] exp_sp,
                           input logic exp_unf, input string tag);
        bus.sp_push = push;
        bus.sp_pop  = pop;
        tick();
        bus.sp_push = 1'b0;
        bus.sp_pop  = 1'b0;
        check({tag, "_sp"}, bus.sp_out, exp_sp);
        check({tag, "_unf"}, bus.sp_unf, exp_unf);
        check({tag, "_ovf"}, bus.sp_ovf, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.rd_addr_a  = '0;
        bus.rd_addr_b  = '0;
        bus2.rd_addr_a = '0;
        bus2.rd_addr_b = '0;
        bus2.wr_en     = 1'b0;
        bus2.wr_addr   = '0;
        bus2.wr_data   = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state on both ports, opposite index orders
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr_a = reg_idx_t'(i);
            bus.rd_addr_b = reg_idx_t'(7 - i);
            #1;
            check($sformatf("rst_rd_a%0d", i), bus.rd_data_a, 32'h0);
            check($sformatf("rst_rd_b%0d", 7 - i), bus.rd_data_b, 32'h0);
        end
        check("rst_sp", bus.sp_out, 32'hFFFF);
        check("rst_ovf", bus.sp_ovf, 1'b0);
        check("rst_unf", bus.sp_unf, 1'b0);

        // Write R3 with both ports looking at it: bypass now, array next cycle
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 16'hA5A5;
        read_check("byp_r3", 3'd3, 16'hA5A5);
        tick();
        idle();
        read_check("arr_r3", 3'd3, 16'hA5A5);
        for (int i = 0; i < 8; i++)
            if (i != 3) read_check($sformatf("other_r%0d", i), reg_idx_t'(i), 16'h0);

        // Ports bypass independently
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 3'd1;
        bus.wr_data   = 16'h0F0F;
        bus.rd_addr_a = 3'd1;
        bus.rd_addr_b = 3'd3;
        #1;
        check("indep_a", bus.rd_data_a, 32'h0F0F);
        check("indep_b", bus.rd_data_b, 32'hA5A5);
        tick();
        idle();
        read_check("arr_r1", 3'd1, 16'h0F0F);

        // Push/pop walk from reset value
        sp_step(1, 0, 16'hFFFE, 0, "push1");
        sp_step(1, 0, 16'hFFFD, 0, "push2");
        sp_step(1, 0, 16'hFFFC, 0, "push3");
        sp_step(1, 1, 16'hFFFC, 0, "both");
        sp_step(0, 1, 16'hFFFD, 0, "pop1");
        sp_step(0, 1, 16'hFFFE, 0, "pop2");
        sp_step(0, 1, 16'hFFFF, 0, "pop3");

        // Underflow saturates and sticks through normal traffic
        sp_step(0, 1, 16'hFFFF, 1, "unf_pop");
        sp_step(1, 0, 16'hFFFE, 1, "unf_s1");
        sp_step(0, 1, 16'hFFFF, 1, "unf_s2");
        sp_step(1, 0, 16'hFFFE, 1, "unf_s3");
        sp_step(1, 1, 16'hFFFE, 1, "unf_s4");
        sp_step(1, 0, 16'hFFFD, 1, "unf_s5");

        // Write and push in the same cycle both land
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd2;
        bus.wr_data = 16'h5555;
        bus.sp_push = 1'b1;
        tick();
        idle();
        read_check("wr_push_r2", 3'd2, 16'h5555);
        check("wr_push_sp", bus.sp_out, 32'hFFFC);

        // Reset beats write and push; bypass still live during reset
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 3'd5;
        bus.wr_data   = 16'h1234;
        bus.sp_push   = 1'b1;
        reset         = 1'b1;
        bus.rd_addr_a = 3'd5;
        bus.rd_addr_b = 3'd3;
        #1;
        check("rstbyp_a", bus.rd_data_a, 32'h1234);
        check("rstbyp_b", bus.rd_data_b, 32'hA5A5);
        tick();
        reset = 1'b0;
        idle();
        read_check("rstpri_r5", 3'd5, 16'h0);
        read_check("rstpri_r3", 3'd3, 16'h0);
        read_check("rstpri_r2", 3'd2, 16'h0);
        check("rstpri_sp", bus.sp_out, 32'hFFFF);
        check("rstpri_ovf", bus.sp_ovf, 1'b0);
        check("rstpri_unf", bus.sp_unf, 1'b0);

        // Reset in the middle of a push stream leaves nothing behind
        sp_step(1, 0, 16'hFFFE, 0, "mid_push1");
        bus.sp_push = 1'b1;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_sp", bus.sp_out, 32'hFFFF);
        tick();
        bus.sp_push = 1'b0;
        check("mid_first_sp", bus.sp_out, 32'hFFFE);

        // Overflow corner on the low-start instance
        check("lo_rst_sp", bus2.sp_out, 32'h0003);
        for (int i = 0; i < 3; i++) begin
            bus2.sp_push = 1'b1;
            tick();
            bus2.sp_push = 1'b0;
            check($sformatf("lo_push%0d", i), bus2.sp_out, 32'(2 - i));
            check($sformatf("lo_push%0d_ovf", i), bus2.sp_ovf, 1'b0);
        end
        bus2.sp_push = 1'b1;
        tick();
        check("ovf_sp", bus2.sp_out, 32'h0);
        check("ovf_flag", bus2.sp_ovf, 1'b1);
        check("ovf_unf", bus2.sp_unf, 1'b0);
        bus2.sp_push = 1'b0;
        bus2.sp_pop  = 1'b1;
        tick();
        bus2.sp_pop = 1'b0;
        check("ovf_pop_sp", bus2.sp_out, 32'h1);
        check("ovf_sticky", bus2.sp_ovf, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_rst_sp", bus2.sp_out, 32'h0003);
        check("ovf_rst_flag", bus2.sp_ovf, 1'b0);
        check("main_rst_sp", bus.sp_out, 32'hFFFF);
        check("main_rst_ovf", bus.sp_ovf, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
